// File: rtl/fan_pwm_gen.sv
`timescale 1ns/1ps
// Fan PWM generator: free-running period counter, mode-to-duty mapping and an
// optional per-period duty ramp. Duty only changes on the period wrap.
module fan_pwm_gen #(
    parameter int CNT_W     = 10,
    parameter int PERIOD    = 1000,
    parameter int LEVELS    = 4,
    parameter int MODE_W    = 2,
    parameter int RAMP_STEP = 111
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_pwm,
    output logic [CNT_W-1:0]  o_counter,
    output logic [CNT_W-1:0]  o_duty,
    output logic              o_period_end,
    output logic              o_busy
);

    localparam int                DUTY_STEP = (PERIOD - 1) / (LEVELS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PERIOD - 1);
    localparam logic [MODE_W-1:0] MAX_MODE  = MODE_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0]  STEP_DUTY = CNT_W'(DUTY_STEP);
    localparam logic [CNT_W:0]    RAMP_W    = (CNT_W + 1)'(RAMP_STEP);

    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  duty;
    logic [CNT_W-1:0]  target;
    logic [MODE_W-1:0] mode_clamped;
    logic [CNT_W-1:0]  new_target;
    logic [CNT_W-1:0]  next_duty;
    logic [CNT_W:0]    duty_up;
    logic [CNT_W:0]    duty_gap;

    // Ramp arithmetic is one bit wider so the step can never wrap past the target.
    always_comb begin
        mode_clamped = (i_mode > MAX_MODE) ? MAX_MODE : i_mode;
        new_target   = CNT_W'(mode_clamped) * STEP_DUTY;
        duty_up      = {1'b0, duty} + RAMP_W;
        duty_gap     = {1'b0, duty} - {1'b0, new_target};
        next_duty    = duty;
        if (RAMP_STEP == 0) begin
            next_duty = new_target;
        end else if (duty < new_target) begin
            next_duty = (duty_up > {1'b0, new_target}) ? new_target : duty_up[CNT_W-1:0];
        end else if (duty > new_target) begin
            next_duty = (duty_gap > RAMP_W) ? (duty - RAMP_W[CNT_W-1:0]) : new_target;
        end
    end

    // Disable clears everything, including on the boundary cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_enable) begin
            counter <= '0;
            duty    <= '0;
            target  <= '0;
        end else if (counter == LAST_CNT) begin
            counter <= '0;
            duty    <= next_duty;
            target  <= new_target;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    assign o_counter    = counter;
    assign o_duty       = duty;
    assign o_pwm        = (counter < duty);
    assign o_period_end = (counter == LAST_CNT);
    assign o_busy       = (duty != target);

endmodule

// File: tb/tb_fan_pwm_gen.sv
`timescale 1ns/1ps
// Bench for fan_pwm_gen: three instances (ramped, direct, three-level direct)
// share stimulus and are checked against an integer reference model.
module tb_fan_pwm_gen;

    localparam int CNT_W  = 10;
    localparam int PER    = 1000;
    localparam int NI     = 3;
    localparam int VEC_W  = 2 * CNT_W + 3;

    // Clock / reset / inputs
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;

    always #5 clk = ~clk;

    logic [CNT_W-1:0] o_cnt  [NI];
    logic [CNT_W-1:0] o_duty [NI];
    logic             o_pwm  [NI];
    logic             o_pe   [NI];
    logic             o_busy [NI];

    fan_pwm_gen #(.CNT_W(CNT_W), .PERIOD(PER), .LEVELS(4), .MODE_W(2), .RAMP_STEP(111)) dut_ramp (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .o_pwm(o_pwm[0]), .o_counter(o_cnt[0]), .o_duty(o_duty[0]),
        .o_period_end(o_pe[0]), .o_busy(o_busy[0]));

    fan_pwm_gen #(.CNT_W(CNT_W), .PERIOD(PER), .LEVELS(4), .MODE_W(2), .RAMP_STEP(0)) dut_direct (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .o_pwm(o_pwm[1]), .o_counter(o_cnt[1]), .o_duty(o_duty[1]),
        .o_period_end(o_pe[1]), .o_busy(o_busy[1]));

    fan_pwm_gen #(.CNT_W(CNT_W), .PERIOD(PER), .LEVELS(3), .MODE_W(2), .RAMP_STEP(0)) dut_lvl3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .o_pwm(o_pwm[2]), .o_counter(o_cnt[2]), .o_duty(o_duty[2]),
        .o_period_end(o_pe[2]), .o_busy(o_busy[2]));

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] exp_q[$];

    function automatic int lv(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic int rs(int k);
        return (k == 0) ? 111 : 0;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Reference model: period position, duty in effect and latched target as integers.
    int m_cnt  [NI];
    int m_duty [NI];
    int m_tgt  [NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n || !en) begin
                m_cnt[k]  = 0;
                m_duty[k] = 0;
                m_tgt[k]  = 0;
            end else if (m_cnt[k] == PER - 1) begin
                m_cnt[k] = 0;
                m_tgt[k] = imin(int'(mode), lv(k) - 1) * ((PER - 1) / (lv(k) - 1));
                if (rs(k) == 0)
                    m_duty[k] = m_tgt[k];
                else if (m_duty[k] < m_tgt[k])
                    m_duty[k] = imin(m_duty[k] + rs(k), m_tgt[k]);
                else
                    m_duty[k] = imax(m_duty[k] - rs(k), m_tgt[k]);
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    end

    function automatic logic [VEC_W-1:0] exp_vec(int k);
        return {CNT_W'(m_cnt[k]), CNT_W'(m_duty[k]), m_cnt[k] < m_duty[k],
                m_cnt[k] == PER - 1, m_duty[k] != m_tgt[k]};
    endfunction

    function automatic logic [VEC_W-1:0] obs_vec(int k);
        return {o_cnt[k], o_duty[k], o_pwm[k], o_pe[k], o_busy[k]};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d: got %h expected 0", k, obs_vec(k));
                end
            end
        end
    endtask

    task automatic test_ramp_up;
        int hi = 0;
        logic [CNT_W-1:0] e;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(CNT_W'(imin(111 * i, 999)));
        rst_n = 1'b1;
        mode  = 2'd3;
        for (int c = 0; c < 11000 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL ramp_up inst%0d cyc %0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            hi += int'(o_pwm[0]);
            if (m_cnt[0] == PER - 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (hi !== int'(e)) begin
                    n_fail++;
                    $display("FAIL ramp_high_time: got %0d high clocks expected %0d", hi, e);
                end
                hi = 0;
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ramp_timeout: got %0d periods left expected 0", exp_q.size());
        end
    endtask

    task automatic test_mode_drop;
        bit dropped = 0;
        logic [CNT_W-1:0] e;
        exp_q.delete();
        for (int i = 1; i <= 9; i++) exp_q.push_back(CNT_W'(imax(999 - 111 * i, 0)));
        for (int c = 0; c < 12000 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL mode_drop inst%0d cyc %0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (dropped && m_cnt[0] == 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (o_duty[0] !== e) begin
                    n_fail++;
                    $display("FAIL ramp_down_step: got %0d expected %0d", o_duty[0], e);
                end
            end
            if (!dropped && m_cnt[0] == 500) begin
                mode    = 2'd0;
                dropped = 1;
            end
        end
        n_cmp++;
        if (o_duty[0] !== '0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ramp_down_floor: got duty %0d (%0d steps left) expected 0", o_duty[0], exp_q.size());
        end
    endtask

    task automatic test_boundary_sample;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL boundary_sample inst%0d cyc %0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            mode = (m_cnt[0] == PER - 1) ? 2'd2 : ((c % 2 == 1) ? 2'd1 : 2'd3);
        end
        n_cmp++;
        if (o_duty[0] !== 10'd666 || o_duty[1] !== 10'd666 || o_duty[2] !== 10'd998 || o_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_target: got %0d/%0d/%0d busy %b expected 666/666/998 busy 0",
                     o_duty[0], o_duty[1], o_duty[2], o_busy[0]);
        end
    endtask

    task automatic test_reset_mid_ramp;
        int phase = 0;
        int after = 0;
        mode = 2'd3;
        for (int c = 0; c < 8000 && phase < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL reset_mid_ramp inst%0d cyc %0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (phase == 0) begin
                rst_n = 1'b0;
                phase = 1;
            end else if (phase == 1) begin
                rst_n = 1'b1;
                phase = 2;
            end else if (phase == 2 && m_duty[0] == 444 && m_cnt[0] == 300) begin
                rst_n = 1'b0;
                phase = 3;
            end else if (phase == 3) begin
                for (int k = 0; k < NI; k++) begin
                    n_cmp++;
                    if (obs_vec(k) !== '0) begin
                        n_fail++;
                        $display("FAIL reset_pulse_clear inst%0d: got %h expected 0", k, obs_vec(k));
                    end
                end
                rst_n = 1'b1;
                phase = 4;
            end else if (phase == 4) begin
                after++;
                if (after == 2500) begin
                    n_cmp++;
                    if (o_duty[0] !== 10'd222 || o_cnt[0] !== 10'd500) begin
                        n_fail++;
                        $display("FAIL ramp_resume: got duty %0d cnt %0d expected 222 / 500", o_duty[0], o_cnt[0]);
                    end
                    phase = 5;
                end
            end
        end
        if (phase != 5) begin
            n_cmp++;
            n_fail++;
            $display("FAIL reset_mid_ramp_timeout: got phase %0d expected 5", phase);
        end
    endtask

    task automatic test_disable;
        int phase = 0;
        mode = 2'd3;
        for (int c = 0; c < 6000 && phase < 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL disable inst%0d cyc %0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (phase == 0 && c >= 1500 && m_cnt[0] == 10) begin
                n_cmp++;
                if (o_duty[2] !== 10'd998) begin
                    n_fail++;
                    $display("FAIL clamp_mode: got %0d expected 998", o_duty[2]);
                end
                en    = 1'b0;
                phase = 1;
            end else if (phase == 1 || phase == 3) begin
                for (int k = 0; k < NI; k++) begin
                    n_cmp++;
                    if (obs_vec(k) !== '0) begin
                        n_fail++;
                        $display("FAIL disable_clear%0d inst%0d: got %h expected 0", phase, k, obs_vec(k));
                    end
                end
                en    = 1'b1;
                phase = phase + 1;
            end else if (phase == 2 && c >= 4000 && m_cnt[0] == PER - 1) begin
                en    = 1'b0;
                phase = 3;
            end
        end
        if (phase != 4) begin
            n_cmp++;
            n_fail++;
            $display("FAIL disable_timeout: got phase %0d expected 4", phase);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc %0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if ($urandom_range(0, 49) == 0 || (m_cnt[0] == PER - 1 && $urandom_range(0, 3) == 0))
                mode = 2'($urandom_range(0, 3));
            if (en && $urandom_range(0, 2999) == 0)
                en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0)
                en = 1'b1;
            rst_n = ($urandom_range(0, 4999) != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        test_reset();
        test_ramp_up();
        test_mode_drop();
        test_boundary_sample();
        test_reset_mid_ramp();
        test_disable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2000000ns expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fan_pwm_gen.md
# fan_pwm_gen

Parametrised PWM generator for the fan controller. It owns its period counter, maps a selected fan mode to a duty threshold, and drives one PWM output. Duty changes are applied only at period boundaries, so the output never glitches. An optional soft-start/soft-stop ramp moves the duty toward its target in fixed steps once per period. It sits between the fan-mode FSM, which supplies `i_mode`, and the fan driver pin.

## Interface
- `CNT_W`, 10: width of the period counter and of the duty values.
- `PERIOD`, 1000: PWM period in clocks. Range 2..2^CNT_W.
- `LEVELS`, 4: number of fan modes. Range 2..2^MODE_W.
- `MODE_W`, 2: width of `i_mode`. Must satisfy 2^MODE_W ≥ LEVELS.
- `RAMP_STEP`, 111: maximum duty change per period. 0 means the target is applied directly.
- `i_clk`, in, 1: clock, rising edge.
- `i_reset_n`, in, 1: reset, synchronous, active-low.
- `i_enable`, in, 1: run enable.
- `i_mode`, in, MODE_W: requested fan mode. 0 is off; LEVELS-1 is maximum.
- `o_pwm`, out, 1: fan PWM drive.
- `o_counter`, out, CNT_W: current period counter.
- `o_duty`, out, CNT_W: duty threshold currently in effect.
- `o_period_end`, out, 1: high while `o_counter` == PERIOD-1.
- `o_busy`, out, 1: high while `o_duty` ≠ latched target.

## Operation
- `DUTY_STEP` = (PERIOD-1)/(LEVELS-1), integer division. The target duty is m·DUTY_STEP. With the defaults the targets are 0/333/666/999.
- An `i_mode` value ≥ LEVELS is clamped to LEVELS-1.
- Counter behaviour:
  - Counts 0..PERIOD-1, then wraps to 0.
  - Held at 0 while `i_enable` = 0.
- `o_pwm` = (`o_counter` < `o_duty`). It is a decode of registered state only; no input reaches it combinationally.
- Boundary update, on the clock edge where the counter wraps (`o_period_end` = 1, `i_enable` = 1):
  - `i_mode` is sampled, clamped and mapped to a new target, which is latched.
  - If RAMP_STEP = 0: duty ← new target.
  - Else if duty < target: duty ← min(duty + RAMP_STEP, target).
  - Else if duty > target: duty ← max(duty − RAMP_STEP, target).
  - The arithmetic must not overflow or underflow. Compute in CNT_W+1 bits, or compare before subtracting.
- `i_mode` changes between boundaries have no effect. Only the value present on the boundary cycle counts.
- `i_enable` = 0, effective on the next edge:
  - counter ← 0; duty ← 0; target ← 0.
  - Consequently `o_pwm` = 0, `o_busy` = 0, `o_period_end` = 0.
- Re-enable:
  - The counter runs from 0.
  - The first boundary latches the mode; from there the ramp starts from 0.
- Reset (`i_reset_n` = 0 at a clock edge) sets counter, duty and target to 0. All outputs are then 0. Reset applies mid-period and mid-ramp with no residue. Reset dominates `i_enable`.

## Timing
- Reset release: the counter reads 0 in the first enabled cycle. With `i_enable` = 1 it increments every cycle.
- The boundary cycle is counter = PERIOD-1. The new duty is visible when the counter reads 0, one cycle after the boundary.
- Every period with counter 0..PERIOD-1 uses exactly one duty value.
- `o_pwm` high time per period = `o_duty` clocks. Extremes:
  - duty 0: never high.
  - duty = PERIOD-1: high for PERIOD-1 clocks.
- Ramp length from duty d to target t = ceil(|t−d| / RAMP_STEP) periods. `o_busy` falls in the cycle the final value takes effect.
- `i_enable` deasserted on the boundary cycle: disable wins and no duty update occurs.

## Test plan
All scenarios use the defaults (PERIOD = 1000, LEVELS = 4, RAMP_STEP = 111) unless stated.
- Release reset, `i_enable` = 1, `i_mode` = 3 held → duty steps 0→111→222…→999 at cycles 1000, 2000, … 9000. `o_busy` drops at cycle 9000. Period 10 shows exactly 999 high clocks and `o_pwm` low at counter 999.
- RAMP_STEP = 0, `i_mode` = 2 → duty 0 during period 1. Duty is 666 from counter 0 of period 2, giving 666 high clocks; `o_busy` = 0 from then on.
- Steady at duty 999. Change `i_mode` to 0 at counter 500 → `o_pwm` unchanged for the rest of the period. Duty then ramps down 888, 777 … 0 over 9 periods with no underflow.
- `i_mode` toggles 1↔3 every cycle except for a 2 at the boundary → target latched is 666. Check there are no spurious duty changes mid-period.
- Mid-ramp at duty 444, counter 300, pulse `i_reset_n` = 0 for 1 cycle → next cycle all outputs are 0 and the counter restarts from 0. The ramp resumes from 0.
- LEVELS = 3, MODE_W = 2, `i_mode` = 3, RAMP_STEP = 0 → clamped to mode 2, so duty = 998 (DUTY_STEP = 499). Then drop `i_enable` at counter 10 → next cycle the counter, `o_duty` and `o_pwm` are all 0.
